switch_mcu_operand_fetch: RTL and testbench
===========================================

# switch_mcu_operand_fetch

Operand-fetch initiator for `switch_mcu_regfile`. It takes one decoded instruction at a time, drives the regfile's two registered read ports, and absorbs their one-cycle read latency. It also forwards writes that race the registered read and hands a complete operand bundle downstream over valid/ready. It sits between decode and execute in the switch core.

## Interface
Parameters:
- `XLEN`, 32, register data width.
- `AW`, 5, register address width.
- `TAG_W`, 32, opaque payload carried with the operands (instruction word or PC).

Ports:
- `in_clk` input 1: sole clock, rising edge.
- `in_rst` input 1: reset, asynchronous, active-high.
- `in_flush` input 1: synchronous; drops the in-flight request and the held bundle.
- `in_req_valid` input 1: decode request valid.
- `out_req_ready` output 1: request accepted when high together with `in_req_valid`.
- `in_req_rs1` / `in_req_rs2` input AW each: source register addresses.
- `in_req_use_rs1` / `in_req_use_rs2` input 1 each: operand needed.
- `in_req_tag` input TAG_W: payload.
- `out_raddr_1` / `out_raddr_2` output AW each: regfile read addresses.
- `out_ren_1` / `out_ren_2` output 1 each: regfile read enables.
- `in_rdata_1` / `in_rdata_2` input XLEN each: regfile read data, valid the cycle after `out_ren_x`.
- `in_wb_en` input 1, `in_wb_addr` input AW, `in_wb_data` input XLEN: snoop of the regfile write port.
- `out_op_valid` output 1: operand bundle valid.
- `in_op_ready` input 1: downstream accepts the bundle.
- `out_op_rs1_data` / `out_op_rs2_data` output XLEN each: operands.
- `out_op_tag` output TAG_W: payload.

## Operation
- FSM states: EMPTY, FETCH, FULL. Reset state is EMPTY.
- `out_req_ready` = !in_flush && (EMPTY || (FULL && in_op_ready)).
- accept = in_req_valid && out_req_ready.
- On accept (combinational, same cycle):
  - `out_raddr_x` = rsX and `out_ren_x` = accept && use_rsX.
  - When there is no accept, both address outputs are 0 and both enables are 0.
  - Latch rs1, rs2, use flags and tag. Go to FETCH.
- Bypass capture in the accept cycle: if in_wb_en && in_wb_addr != 0 && in_wb_addr == rsX, latch byp_vX=1 and byp_dX=in_wb_data. Otherwise byp_vX=0.
- FETCH, one cycle. Operand register X loads, in priority order:
  - 0 if !use_rsX or rsX==0;
  - else in_wb_data if a current write matches rsX (nonzero);
  - else byp_dX if byp_vX;
  - else in_rdata_X.
  - Then go to FULL.
- FULL: `out_op_valid`=1.
  - Each cycle, any write with nonzero address matching a used rsX overwrites operand X. Held operands therefore track older in-order writebacks.
  - On in_op_ready: go to FETCH if accept, else EMPTY.
- Writes to address 0 are never forwarded. The regfile returns 0 for address 0 on its own.
- in_flush has priority over everything except reset:
  - Next state is EMPTY and no accept happens that cycle.
  - `out_op_valid` drops the next cycle.
  - Any regfile read in flight is ignored.

## Timing
- Reset values:
  - `out_req_ready` =1 (combinational from EMPTY).
  - `out_op_valid`, all `out_op_*` data/tag, bypass registers: 0.
  - `out_raddr_x` and `out_ren_x` are 0 unless in_req_valid is high.
- Latency: accept in cycle N means `out_op_valid` in cycle N+2.
- Sustained throughput: one bundle per 2 cycles.
- `out_op_*` stay stable while out_op_valid && !in_op_ready, except for snoop updates of matching operands.
- Assertion of in_rst mid-FETCH or mid-FULL discards everything asynchronously.
- `out_req_ready` depends combinationally on in_op_ready and in_flush. There is no combinational path from in_req_valid to out_req_ready.

## Structure
- Shared package `switch_mcu_pkg` holds:
  - the state enum `opf_state_t` (EMPTY=0, FETCH=1, FULL=2);
  - the constants `REG_ZERO=0`, `XLEN`, `AW`.
- Natural sub-module: `switch_mcu_opf_bypass`, instantiated once per operand. It is purely combinational: the priority mux from matching write to latched bypass to regfile data, with the zero rules.

## Test plan
- Regfile x3=0x11, x4=0x22. Request rs1=3, rs2=4 with both operands used and tag 0xA5 → `out_ren_1/2`=1, addresses 3/4 in cycle N; out_op_valid in N+2 with 0x11 / 0x22 / 0xA5.
- Write x3=0x99 in the accept cycle → rs1 operand is 0x99. Repeat with the write in the FETCH cycle → also 0x99.
- Hold in_op_ready=0 for 5 cycles in FULL and write x4=0x77 in cycle 2 → rs2 becomes 0x77. rs1 and the tag are unchanged, and out_req_ready=0 throughout.
- rs1=0 with a concurrent write to address 0 of 0xFFFF, and use_rs2=0 → both operands are 0 and out_ren_2=0.
- Back-to-back requests with in_op_ready tied 1 → bundles arrive every 2 cycles in order, and accept occurs in the same cycle as the FULL handshake.
- Assert in_flush in FETCH and then in FULL → out_op_valid=0 next cycle and state is EMPTY. Pulsing in_rst asynchronously in FULL clears all outputs immediately.

Source files
------------

// File: rtl/switch_mcu_pkg.sv
// switch_mcu_pkg: shared types and constants for the switch core operand path
package switch_mcu_pkg;
  localparam int XLEN = 32;
  localparam int AW = 5;
  localparam int REG_ZERO = 0;
  typedef enum logic [1:0] {EMPTY = 2'd0, FETCH = 2'd1, FULL = 2'd2} opf_state_t;
endpackage

// File: rtl/switch_mcu_opf_bypass.sv
// switch_mcu_opf_bypass: operand select, live write over latched bypass over regfile data
import switch_mcu_pkg::*;
module switch_mcu_opf_bypass #(
  parameter int XLEN = 32,
  parameter int AW = 5
) (
  input  logic            use_rs,
  input  logic [AW-1:0]   rs,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            byp_v,
  input  logic [XLEN-1:0] byp_d,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data
);
  always_comb data = (!use_rs || rs == AW'(REG_ZERO)) ? '0 :
                     (wb_en && wb_addr == rs) ? wb_data :
                     byp_v ? byp_d : rdata;
endmodule

// File: rtl/switch_mcu_operand_fetch.sv
// switch_mcu_operand_fetch: drives the regfile read ports, absorbs read latency and
// forwards racing writebacks into a valid/ready operand bundle
import switch_mcu_pkg::*;
module switch_mcu_operand_fetch #(
  parameter int XLEN = 32,
  parameter int AW = 5,
  parameter int TAG_W = 32
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_flush,
  input  logic             in_req_valid,
  output logic             out_req_ready,
  input  logic [AW-1:0]    in_req_rs1,
  input  logic [AW-1:0]    in_req_rs2,
  input  logic             in_req_use_rs1,
  input  logic             in_req_use_rs2,
  input  logic [TAG_W-1:0] in_req_tag,
  output logic [AW-1:0]    out_raddr_1,
  output logic [AW-1:0]    out_raddr_2,
  output logic             out_ren_1,
  output logic             out_ren_2,
  input  logic [XLEN-1:0]  in_rdata_1,
  input  logic [XLEN-1:0]  in_rdata_2,
  input  logic             in_wb_en,
  input  logic [AW-1:0]    in_wb_addr,
  input  logic [XLEN-1:0]  in_wb_data,
  output logic             out_op_valid,
  input  logic             in_op_ready,
  output logic [XLEN-1:0]  out_op_rs1_data,
  output logic [XLEN-1:0]  out_op_rs2_data,
  output logic [TAG_W-1:0] out_op_tag
);
  opf_state_t state, state_nxt;
  logic accept, live, byp_hit_1, byp_hit_2, byp_v_1, byp_v_2, use_1, use_2;
  logic [AW-1:0] rs_1, rs_2;
  logic [XLEN-1:0] byp_d_1, byp_d_2, mux_1, mux_2;
  logic [TAG_W-1:0] tag_q;
  assign out_req_ready = !in_flush && (state == EMPTY || (state == FULL && in_op_ready));
  assign accept = in_req_valid && out_req_ready;
  assign out_raddr_1 = accept ? in_req_rs1 : '0;
  assign out_raddr_2 = accept ? in_req_rs2 : '0;
  assign out_ren_1 = accept && in_req_use_rs1;
  assign out_ren_2 = accept && in_req_use_rs2;
  assign out_op_valid = state == FULL;
  assign out_op_tag = tag_q;
  assign byp_hit_1 = in_wb_en && in_wb_addr != AW'(REG_ZERO) && in_wb_addr == in_req_rs1;
  assign byp_hit_2 = in_wb_en && in_wb_addr != AW'(REG_ZERO) && in_wb_addr == in_req_rs2;
  // In FULL the mux feeds back the held operand so only a matching write changes it
  assign live = !in_flush && (state == FETCH || state == FULL);
  always_comb state_nxt = in_flush ? EMPTY :
                          accept ? FETCH :
                          state == FETCH ? FULL :
                          (state == FULL && in_op_ready) ? EMPTY : state;
  switch_mcu_opf_bypass #(.XLEN(XLEN), .AW(AW)) u_byp_1 (
    .use_rs(use_1), .rs(rs_1), .wb_en(in_wb_en), .wb_addr(in_wb_addr), .wb_data(in_wb_data),
    .byp_v(state == FETCH && byp_v_1), .byp_d(byp_d_1),
    .rdata(state == FETCH ? in_rdata_1 : out_op_rs1_data), .data(mux_1)
  );
  switch_mcu_opf_bypass #(.XLEN(XLEN), .AW(AW)) u_byp_2 (
    .use_rs(use_2), .rs(rs_2), .wb_en(in_wb_en), .wb_addr(in_wb_addr), .wb_data(in_wb_data),
    .byp_v(state == FETCH && byp_v_2), .byp_d(byp_d_2),
    .rdata(state == FETCH ? in_rdata_2 : out_op_rs2_data), .data(mux_2)
  );
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state <= EMPTY;
      rs_1 <= '0;
      rs_2 <= '0;
      use_1 <= 1'b0;
      use_2 <= 1'b0;
      tag_q <= '0;
      byp_v_1 <= 1'b0;
      byp_v_2 <= 1'b0;
      byp_d_1 <= '0;
      byp_d_2 <= '0;
      out_op_rs1_data <= '0;
      out_op_rs2_data <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rs_1 <= in_req_rs1;
        rs_2 <= in_req_rs2;
        use_1 <= in_req_use_rs1;
        use_2 <= in_req_use_rs2;
        tag_q <= in_req_tag;
        byp_v_1 <= byp_hit_1;
        byp_v_2 <= byp_hit_2;
        byp_d_1 <= byp_hit_1 ? in_wb_data : '0;
        byp_d_2 <= byp_hit_2 ? in_wb_data : '0;
      end
      if (live) begin
        out_op_rs1_data <= mux_1;
        out_op_rs2_data <= mux_2;
      end
    end
  end
endmodule

// File: tb/tb_switch_mcu_operand_fetch.sv
// tb_switch_mcu_operand_fetch: directed and random checks against a register-file view
// of what each held operand must equal
module tb_switch_mcu_operand_fetch;
  logic in_clk = 0, in_rst = 1, in_flush = 0, in_req_valid = 0, out_req_ready;
  logic [4:0] in_req_rs1 = 0, in_req_rs2 = 0, out_raddr_1, out_raddr_2, in_wb_addr = 0;
  logic in_req_use_rs1 = 0, in_req_use_rs2 = 0, out_ren_1, out_ren_2, in_wb_en = 0;
  logic [31:0] in_req_tag = 0, in_rdata_1, in_rdata_2, in_wb_data = 0;
  logic out_op_valid, in_op_ready = 0;
  logic [31:0] out_op_rs1_data, out_op_rs2_data, out_op_tag;
  logic [31:0] mem [32];
  int total = 0, bad = 0;
  typedef struct {logic [4:0] rs1, rs2; logic u1, u2; logic [31:0] tag;} req_t;
  req_t m_req;
  int m_st = 0;
  always #5 in_clk = ~in_clk;
  switch_mcu_operand_fetch dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_flush(in_flush), .in_req_valid(in_req_valid),
    .out_req_ready(out_req_ready), .in_req_rs1(in_req_rs1), .in_req_rs2(in_req_rs2),
    .in_req_use_rs1(in_req_use_rs1), .in_req_use_rs2(in_req_use_rs2), .in_req_tag(in_req_tag),
    .out_raddr_1(out_raddr_1), .out_raddr_2(out_raddr_2), .out_ren_1(out_ren_1),
    .out_ren_2(out_ren_2), .in_rdata_1(in_rdata_1), .in_rdata_2(in_rdata_2),
    .in_wb_en(in_wb_en), .in_wb_addr(in_wb_addr), .in_wb_data(in_wb_data),
    .out_op_valid(out_op_valid), .in_op_ready(in_op_ready), .out_op_rs1_data(out_op_rs1_data),
    .out_op_rs2_data(out_op_rs2_data), .out_op_tag(out_op_tag)
  );
  always @(posedge in_clk) begin
    if (in_rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= 0;
      in_rdata_1 <= 0;
      in_rdata_2 <= 0;
    end else begin
      if (out_ren_1) in_rdata_1 <= mem[out_raddr_1];
      if (out_ren_2) in_rdata_2 <= mem[out_raddr_2];
      if (in_wb_en && in_wb_addr != 0) mem[in_wb_addr] <= in_wb_data;
    end
  end
  function automatic logic [31:0] exp_op(input logic [4:0] rs, input logic u);
    return (u && rs != 0) ? mem[rs] : 32'h0;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic rv, input logic [4:0] a1, input logic [4:0] a2,
                      input logic u1, input logic u2, input logic [31:0] tg,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic rdy, input logic fl);
    logic exp_rdy, acc;
    in_req_valid = rv; in_req_rs1 = a1; in_req_rs2 = a2;
    in_req_use_rs1 = u1; in_req_use_rs2 = u2; in_req_tag = tg;
    in_wb_en = we; in_wb_addr = wa; in_wb_data = wd; in_op_ready = rdy; in_flush = fl;
    #1;
    exp_rdy = !fl && (m_st == 0 || (m_st == 2 && rdy));
    acc = rv && exp_rdy;
    chk("req_ready", {31'b0, out_req_ready}, {31'b0, exp_rdy});
    chk("ren_1", {31'b0, out_ren_1}, {31'b0, acc && u1});
    chk("ren_2", {31'b0, out_ren_2}, {31'b0, acc && u2});
    chk("raddr_1", {27'b0, out_raddr_1}, acc ? {27'b0, a1} : 32'h0);
    chk("raddr_2", {27'b0, out_raddr_2}, acc ? {27'b0, a2} : 32'h0);
    chk("op_valid", {31'b0, out_op_valid}, {31'b0, m_st == 2});
    if (m_st == 2) begin
      chk("rs1_data", out_op_rs1_data, exp_op(m_req.rs1, m_req.u1));
      chk("rs2_data", out_op_rs2_data, exp_op(m_req.rs2, m_req.u2));
      chk("tag", out_op_tag, m_req.tag);
    end
    m_st = fl ? 0 : acc ? 1 : m_st == 1 ? 2 : (m_st == 2 && rdy) ? 0 : m_st;
    if (acc) m_req = '{a1, a2, u1, u2, tg};
    @(posedge in_clk);
    #1;
  endtask
  task automatic idle(input logic rdy);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, rdy, 0);
  endtask
  initial begin
    repeat (2) @(posedge in_clk);
    #1 in_rst = 0;
    #1;
    chk("rst_req_ready", {31'b0, out_req_ready}, 32'h1);
    chk("rst_op_valid", {31'b0, out_op_valid}, 32'h0);
    chk("rst_rs1", out_op_rs1_data, 32'h0);
    chk("rst_tag", out_op_tag, 32'h0);
    chk("rst_ren", {30'b0, out_ren_1, out_ren_2}, 32'h0);
    step(0, 0, 0, 0, 0, 0, 1, 3, 32'h11, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 4, 32'h22, 1, 0);
    step(1, 3, 4, 1, 1, 32'hA5, 0, 0, 0, 0, 0);
    idle(0);
    chk("basic_rs1", out_op_rs1_data, 32'h11);
    chk("basic_rs2", out_op_rs2_data, 32'h22);
    idle(1);
    step(1, 3, 4, 1, 1, 32'h1, 1, 3, 32'h99, 0, 0);
    idle(0);
    chk("byp_accept", out_op_rs1_data, 32'h99);
    idle(1);
    step(1, 3, 4, 1, 1, 32'h2, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 3, 32'h55, 0, 0);
    chk("byp_fetch", out_op_rs1_data, 32'h55);
    idle(1);
    step(1, 3, 4, 1, 1, 32'h3, 0, 0, 0, 0, 0);
    idle(0);
    idle(0);
    step(1, 9, 9, 1, 1, 32'h33, 1, 4, 32'h77, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 9, 9, 1, 1, 32'h33, 0, 0, 0, 0, 0);
    chk("hold_rs2", out_op_rs2_data, 32'h77);
    chk("hold_rs1", out_op_rs1_data, 32'h55);
    chk("hold_tag", out_op_tag, 32'h3);
    idle(1);
    step(1, 0, 4, 1, 0, 32'h4, 1, 0, 32'hFFFF, 0, 0);
    idle(0);
    chk("zero_rs1", out_op_rs1_data, 32'h0);
    chk("zero_rs2", out_op_rs2_data, 32'h0);
    idle(1);
    for (int i = 0; i < 8; i++)
      step(1, 5'(i % 8), 5'((i + 3) % 8), 1, 1, 32'h100 + i, 1, 5'(i % 8), 32'h200 + i, 1, 0);
    idle(1);
    idle(1);
    step(1, 3, 4, 1, 1, 32'h5, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(0);
    step(1, 3, 4, 1, 1, 32'h6, 0, 0, 0, 0, 0);
    idle(0);
    step(1, 5, 5, 1, 1, 32'h7, 0, 0, 0, 1, 1);
    idle(0);
    step(1, 3, 4, 1, 1, 32'h8, 0, 0, 0, 0, 0);
    idle(0);
    in_req_valid = 0;
    #2 in_rst = 1;
    #1;
    chk("arst_op_valid", {31'b0, out_op_valid}, 32'h0);
    chk("arst_rs1", out_op_rs1_data, 32'h0);
    chk("arst_rs2", out_op_rs2_data, 32'h0);
    chk("arst_tag", out_op_tag, 32'h0);
    chk("arst_ready", {31'b0, out_req_ready}, 32'h1);
    @(posedge in_clk);
    #1 in_rst = 0;
    m_st = 0;
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
